// File: rtl/md_sched.sv
// HI/LO arithmetic scheduler: accepts MULT/MULTU/DIV/DIVU requests, sequences the
// external multiplier or divider, and writes the HI/LO pair back after completion.
module md_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        req_ready,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic        div_busy,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  output logic        mult_start,
  output logic        mult_signed,
  output logic [31:0] mult_a,
  output logic [31:0] mult_b,
  input  logic        mult_busy,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  output logic        hi_we,
  output logic        lo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata,
  output logic        done,
  output logic        dbz,
  input  logic        hilo_rd,
  output logic        stall
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WRITE} state_t;

  state_t      state_q, state_d;
  logic        is_div_q, sgn_q, dbz_q, busy_seen_q;
  logic [5:0]  wd_q;
  logic [31:0] a_q, b_q, hi_q, lo_q;

  logic accept, req_dbz, unit_busy, unit_done, wd_expire;

  assign accept    = (state_q == IDLE) && req_valid;
  assign req_dbz   = req_op[1] && (req_b == 32'd0);
  assign unit_busy = is_div_q ? div_busy : mult_busy;
  assign unit_done = busy_seen_q && !unit_busy;
  // wd_q reaches 63 on the same edge that leaves WAIT, i.e. after 63 WAIT cycles.
  assign wd_expire = (wd_q == 6'd62);

  // NOTE: every variable is given a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (req_valid) state_d = req_dbz ? WRITE : ISSUE;
      ISSUE: state_d = WAIT;
      WAIT:  if (unit_done || wd_expire) state_d = WRITE;
      WRITE: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      is_div_q    <= 1'b0;
      sgn_q       <= 1'b0;
      dbz_q       <= 1'b0;
      busy_seen_q <= 1'b0;
      wd_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        is_div_q    <= req_op[1];
        sgn_q       <= ~req_op[0];
        dbz_q       <= req_dbz;
        a_q         <= req_a;
        b_q         <= req_b;
        busy_seen_q <= 1'b0;
        wd_q        <= '0;
        if (req_dbz) begin
          hi_q <= req_a;
          lo_q <= 32'hFFFF_FFFF;
        end
      end
      if (state_q == WAIT) begin
        wd_q <= wd_q + 6'd1;
        if (unit_busy) busy_seen_q <= 1'b1;
        if (unit_done) begin
          hi_q <= is_div_q ? div_r : mult_hi;
          lo_q <= is_div_q ? div_q : mult_lo;
        end else if (wd_expire) begin
          hi_q <= '0;
          lo_q <= '0;
        end
      end
    end
  end

  // Starts decode straight from the state register so reset removes them asynchronously.
  assign req_ready    = rst && (state_q == IDLE);
  assign div_start    = (state_q == ISSUE) && is_div_q;
  assign mult_start   = (state_q == ISSUE) && !is_div_q;
  assign div_signed   = sgn_q && is_div_q;
  assign mult_signed  = sgn_q && !is_div_q;
  assign div_dividend = a_q;
  assign div_divisor  = b_q;
  assign mult_a       = a_q;
  assign mult_b       = b_q;
  assign done         = (state_q == WRITE);
  assign hi_we        = done;
  assign lo_we        = done;
  assign dbz          = done && dbz_q;
  assign hi_wdata     = done ? hi_q : 32'd0;
  assign lo_wdata     = done ? lo_q : 32'd0;
  assign stall        = (state_q != IDLE) && (req_valid || hilo_rd);

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched with simple behavioural multiplier and divider models.
module tb_md_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_a = '0, req_b = '0;
  logic        req_ready, div_start, div_signed, mult_start, mult_signed;
  logic [31:0] div_dividend, div_divisor, mult_a, mult_b;
  logic        div_busy, mult_busy;
  logic [31:0] div_q = '0, div_r = '0, mult_hi = '0, mult_lo = '0;
  logic        hi_we, lo_we, done, dbz, stall;
  logic [31:0] hi_wdata, lo_wdata;
  logic        hilo_rd = 1'b0;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  md_sched dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .div_start(div_start), .div_signed(div_signed),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_busy(div_busy),
    .div_q(div_q), .div_r(div_r), .mult_start(mult_start), .mult_signed(mult_signed),
    .mult_a(mult_a), .mult_b(mult_b), .mult_busy(mult_busy), .mult_hi(mult_hi),
    .mult_lo(mult_lo), .hi_we(hi_we), .lo_we(lo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
    .done(done), .dbz(dbz), .hilo_rd(hilo_rd), .stall(stall)
  );

  always #5 clk = ~clk;

  // Unit models: busy rises the cycle after start and stays high for *_lat cycles.
  int   div_lat = 3, mult_lat = 2, div_cnt = 0, mult_cnt = 0;
  logic div_hang = 1'b0;
  assign div_busy  = div_hang || (div_cnt != 0);
  assign mult_busy = (mult_cnt != 0);

  function automatic logic [63:0] model_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a; sb = b;
    if (sgn) model_div = {32'(sa % sb), 32'(sa / sb)};
    else     model_div = {a % b, a / b};
  endfunction

  function automatic logic [63:0] model_mul(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    if (sgn) begin
      sa = {{32{a[31]}}, a}; sb = {{32{b[31]}}, b};
      model_mul = 64'(sa * sb);
    end else begin
      model_mul = {32'd0, a} * {32'd0, b};
    end
  endfunction

  always @(posedge clk) begin
    if (div_start) begin
      div_cnt <= div_lat;
      {div_r, div_q} <= model_div(div_signed, div_dividend, div_divisor);
    end else if (div_cnt != 0) div_cnt <= div_cnt - 1;
    if (mult_start) begin
      mult_cnt <= mult_lat;
      {mult_hi, mult_lo} <= model_mul(mult_signed, mult_a, mult_b);
    end else if (mult_cnt != 0) mult_cnt <= mult_cnt - 1;
  end

  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Results of the most recent run_op.
  int          lat, n_ds, n_ms, stall_bad, opnd_bad;
  logic        found, sgn, got_we, got_dbz, post_done, post_ready, post_stall;
  logic [31:0] got_hi, got_lo;

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic hilo);
    lat = 0; n_ds = 0; n_ms = 0; stall_bad = 0; opnd_bad = 0;
    found = 1'b0; sgn = 1'b0; got_we = 1'b0; got_dbz = 1'b0; got_hi = '0; got_lo = '0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; hilo_rd = hilo;
    @(negedge clk);
    req_valid = 1'b0; req_a = ~a; req_b = ~b;
    for (int i = 1; i <= 200 && !found; i++) begin
      if (i > 1) @(negedge clk);
      if (div_start)  begin n_ds++; sgn = div_signed;  end
      if (mult_start) begin n_ms++; sgn = mult_signed; end
      if (hilo && !stall) stall_bad++;
      if (op[1] ? (div_dividend !== a || div_divisor !== b) : (mult_a !== a || mult_b !== b))
        opnd_bad++;
      if (done) begin
        found = 1'b1; lat = i; got_hi = hi_wdata; got_lo = lo_wdata;
        got_we = hi_we && lo_we; got_dbz = dbz;
      end
    end
    @(negedge clk);
    post_done = done; post_ready = req_ready; post_stall = stall;
    hilo_rd = 1'b0;
  endtask

  int n_done;

  initial begin
    // Reset state
    #12;
    check("rst_done", 32'(done), 0);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_hi_we", 32'(hi_we), 0);
    check("rst_start", 32'({div_start, mult_start}), 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(req_ready), 1);
    check("stall_idle", 32'(stall), 0);

    // Signed divide
    run_op(OP_DIV, 32'hFF333F3F, 32'hFFAFF222, 1'b0);
    check("div_found", 32'(found), 1);
    check("div_lat", 32'(lat), 6);
    check("div_nstart", 32'(n_ds), 1);
    check("div_nmstart", 32'(n_ms), 0);
    check("div_signed", 32'(sgn), 1);
    check("div_hi", got_hi, 32'hFFD35AFB);
    check("div_lo", got_lo, 32'h00000002);
    check("div_we", 32'(got_we), 1);
    check("div_dbz", 32'(got_dbz), 0);
    check("div_opnd_hold", 32'(opnd_bad), 0);
    check("div_done_1cyc", 32'(post_done), 0);

    // Unsigned divide
    run_op(OP_DIVU, 32'hFF333F3F, 32'hFFAFF222, 1'b0);
    check("divu_signed", 32'(sgn), 0);
    check("divu_hi", got_hi, 32'hFF333F3F);
    check("divu_lo", got_lo, 32'h00000000);

    // Divide by zero
    run_op(OP_DIV, 32'h00000007, 32'h00000000, 1'b0);
    check("dbz_lat", 32'(lat), 1);
    check("dbz_nstart", 32'(n_ds + n_ms), 0);
    check("dbz_flag", 32'(got_dbz), 1);
    check("dbz_hi", got_hi, 32'h00000007);
    check("dbz_lo", got_lo, 32'hFFFFFFFF);

    // Multiplies
    run_op(OP_MULT, 32'hFFFFFFFF, 32'h00000002, 1'b0);
    check("mult_lat", 32'(lat), 5);
    check("mult_nstart", 32'(n_ms), 1);
    check("mult_ndstart", 32'(n_ds), 0);
    check("mult_signed", 32'(sgn), 1);
    check("mult_hi", got_hi, 32'hFFFFFFFF);
    check("mult_lo", got_lo, 32'hFFFFFFFE);
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 1'b0);
    check("multu_signed", 32'(sgn), 0);
    check("multu_ndstart", 32'(n_ds), 0);
    check("multu_hi", got_hi, 32'h00000001);
    check("multu_lo", got_lo, 32'hFFFFFFFE);

    // HI/LO read during a divide
    run_op(OP_DIV, 32'd100, 32'd7, 1'b1);
    check("hilo_stall_busy", 32'(stall_bad), 0);
    check("hilo_stall_idle", 32'(post_stall), 0);
    check("hilo_div_lo", got_lo, 32'd14);
    check("hilo_div_hi", got_hi, 32'd2);

    // Back-to-back request held through WRITE
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_DIV; req_a = 32'd100; req_b = 32'd7;
    @(negedge clk);
    req_op = OP_MULTU; req_a = 32'd3; req_b = 32'd5;
    found = 1'b0; n_ms = 0; opnd_bad = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (i > 0) @(negedge clk);
      if (mult_start) n_ms++;
      if (req_ready) opnd_bad++;
      if (done) found = 1'b1;
    end
    check("b2b_found", 32'(found), 1);
    check("b2b_no_early", 32'(n_ms + opnd_bad), 0);
    @(negedge clk);
    check("b2b_idle_ready", 32'(req_ready), 1);
    check("b2b_idle_nostart", 32'(mult_start), 0);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_issue", 32'(mult_start), 1);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (done) begin found = 1'b1; got_hi = hi_wdata; got_lo = lo_wdata; end
    end
    check("b2b_found2", 32'(found), 1);
    check("b2b_lo", got_lo, 32'd15);
    check("b2b_hi", got_hi, 32'd0);

    // Reset during ISSUE drops the start pulse at once
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_DIV; req_a = 32'd50; req_b = 32'd5;
    @(negedge clk);
    req_valid = 1'b0;
    check("issue_start", 32'(div_start), 1);
    rst = 1'b0; #1;
    check("rst_issue_start", 32'(div_start), 0);
    check("rst_issue_opnd", div_dividend, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);

    // Reset during WAIT: no write-back
    div_lat = 10;
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_DIV; req_a = 32'd50; req_b = 32'd5;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0; #1;
    check("rst_wait_done", 32'(done), 0);
    check("rst_wait_divisor", div_divisor, 32'd0);
    check("rst_wait_stall", 32'(stall), 0);
    n_done = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 1) rst = 1'b1;
      if (done || hi_we) n_done++;
    end
    check("rst_wait_nodone", 32'(n_done), 0);
    check("rst_wait_ready", 32'(req_ready), 1);
    div_lat = 3;

    // Watchdog: divider never drops busy
    div_hang = 1'b1;
    run_op(OP_DIV, 32'd9, 32'd3, 1'b0);
    div_hang = 1'b0;
    check("wd_found", 32'(found), 1);
    check("wd_lat", 32'(lat), 65);
    check("wd_hi", got_hi, 32'd0);
    check("wd_lo", got_lo, 32'd0);
    check("wd_ready", 32'(post_ready), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
